// File: rtl/gray_pingpong_buf_if.sv
// Bus bundle for the grey-pixel ping-pong buffer: writer side, SAD reader
// side and frame status. The master is the producer/SAD side and the slave
// is the buffer.
interface gray_pingpong_buf_if #(
    parameter int MEAN_SIZE      = 4,
    parameter int BUF_ADDR_WIDTH = 1
);
    logic [MEAN_SIZE-1:0]      wr_data;
    logic [BUF_ADDR_WIDTH-1:0] wr_addr;
    logic                      wr_valid;
    logic                      wr_ready;
    logic                      frame_valid;
    logic                      rd_en;
    logic [BUF_ADDR_WIDTH-1:0] rd_addr;
    logic [MEAN_SIZE-1:0]      rd_data;
    logic                      sad_done;
    logic [7:0]                frame_cnt;
    logic                      addr_err;

    modport master (
        output wr_data, wr_addr, wr_valid, rd_en, rd_addr, sad_done,
        input  wr_ready, frame_valid, rd_data, frame_cnt, addr_err
    );

    modport slave (
        input  wr_data, wr_addr, wr_valid, rd_en, rd_addr, sad_done,
        output wr_ready, frame_valid, rd_data, frame_cnt, addr_err
    );
endinterface

// File: rtl/gray_pingpong_buf.sv
// Two-bank ping-pong frame buffer between the grey mean stage (writer) and
// the SAD engine (reader). The writer fills bank wb; a completed bank is
// marked full and handed to the reader, which releases it with sad_done.
module gray_pingpong_buf #(
    parameter int CAMERA_HSIZE   = 1,
    parameter int CAMERA_VSIZE   = 1,
    parameter int MEAN_SIZE      = 4,
    parameter int BUF_ADDR_WIDTH = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    gray_pingpong_buf_if.slave  bus
);
    localparam int FRAME = CAMERA_HSIZE * CAMERA_VSIZE;
    localparam int DEPTH = 1 << BUF_ADDR_WIDTH;
    // FRAME fits in one extra address bit because FRAME <= 2^BUF_ADDR_WIDTH
    localparam logic [BUF_ADDR_WIDTH:0]   FRAME_W   = (BUF_ADDR_WIDTH+1)'(FRAME);
    localparam logic [BUF_ADDR_WIDTH-1:0] LAST_WORD = BUF_ADDR_WIDTH'(FRAME - 1);

    logic [1:0]                full_reg, full_next;
    logic                      wb_reg, rb_reg;
    logic [BUF_ADDR_WIDTH-1:0] wcnt_reg, wcnt_next;
    logic [7:0]                frame_cnt_reg;
    logic                      addr_err_reg;
    logic [MEAN_SIZE-1:0]      rd_data_reg;
    logic [1:0][MEAN_SIZE-1:0] bank_rd;

    logic wr_ready, frame_valid;
    logic wr_fire, wr_in_range, rd_in_range;
    logic wr_store, bank_done, bank_free, rd_fire;

    assign wr_ready    = ~full_reg[wb_reg];
    assign frame_valid = full_reg[rb_reg];
    assign wr_fire     = bus.wr_valid & wr_ready;
    assign wr_in_range = ({1'b0, bus.wr_addr} < FRAME_W);
    assign rd_in_range = ({1'b0, bus.rd_addr} < FRAME_W);
    assign wr_store    = wr_fire & wr_in_range;
    assign bank_done   = wr_store & (wcnt_reg == LAST_WORD);
    assign bank_free   = bus.sad_done & frame_valid;
    assign rd_fire     = bus.rd_en & frame_valid;

    assign bus.wr_ready    = wr_ready;
    assign bus.frame_valid = frame_valid;
    assign bus.rd_data     = rd_data_reg;
    assign bus.frame_cnt   = frame_cnt_reg;
    assign bus.addr_err    = addr_err_reg;

    // Next full flags and write count; completion and release never hit the
    // same bank because a full write bank blocks the completing write.
    always_comb begin
        full_next = full_reg;
        wcnt_next = wcnt_reg;
        if (wr_store) begin
            wcnt_next = bank_done ? '0 : wcnt_reg + 1'b1;
        end
        if (bank_done) begin
            full_next[wb_reg] = 1'b1;
        end
        if (bank_free) begin
            full_next[rb_reg] = 1'b0;
        end
    end

    // Bank bookkeeping, frame counter and sticky address error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_reg      <= '0;
            wb_reg        <= 1'b0;
            rb_reg        <= 1'b0;
            wcnt_reg      <= '0;
            frame_cnt_reg <= '0;
            addr_err_reg  <= 1'b0;
        end else begin
            full_reg <= full_next;
            wcnt_reg <= wcnt_next;
            if (bank_done) begin
                wb_reg        <= ~wb_reg;
                frame_cnt_reg <= frame_cnt_reg + 8'd1;
            end
            if (bank_free) begin
                rb_reg <= ~rb_reg;
            end
            if (wr_fire && !wr_in_range) begin
                addr_err_reg <= 1'b1;
            end
        end
    end

    // Registered read port; uses the read bank as it was before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_reg <= '0;
        end else if (rd_fire) begin
            rd_data_reg <= rd_in_range ? bank_rd[rb_reg] : '0;
        end
    end

    // One storage array per bank; contents survive reset.
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [MEAN_SIZE-1:0] bank_mem [0:DEPTH-1];

        // Store an in-range pixel when this bank is the write bank.
        always_ff @(posedge clk) begin
            if (wr_store && (wb_reg == 1'(gi))) begin
                bank_mem[bus.wr_addr] <= bus.wr_data;
            end
        end

        assign bank_rd[gi] = bank_mem[bus.rd_addr];
    end
endmodule

// File: tb/tb_gray_pingpong_buf.sv
// Randomised and directed bench for gray_pingpong_buf. The driver updates a
// frame-level model and queues the expected outputs; a monitor compares them.
module tb_gray_pingpong_buf;
    localparam int HS = 3, VS = 2, MS = 4, AW = 3;
    localparam int FRAME = HS * VS;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gray_pingpong_buf_if #(.MEAN_SIZE(MS), .BUF_ADDR_WIDTH(AW)) bus ();

    gray_pingpong_buf #(
        .CAMERA_HSIZE(HS), .CAMERA_VSIZE(VS),
        .MEAN_SIZE(MS), .BUF_ADDR_WIDTH(AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit rdy;
        bit fv;
        int cnt;
        bit err;
        int rd;
    } exp_t;

    exp_t exp_q[$];
    int   chk_cnt  = 0;
    int   fail_cnt = 0;
    int   step_no  = 0;

    // Reference model: banks are handed out by counting completed and
    // released frames; memory is a plain array per bank.
    int completed, released, wcnt, m_rd;
    bit m_err;
    int mem [2][8];

    function automatic void chk(string name, logic [31:0] act, int exp_v);
        chk_cnt++;
        if (act !== exp_v) begin
            fail_cnt++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp_v);
        end
    endfunction

    function automatic exp_t model_status();
        exp_t e;
        e.rdy = (completed - released) < 2;
        e.fv  = (completed - released) > 0;
        e.cnt = completed % 256;
        e.err = m_err;
        e.rd  = m_rd;
        return e;
    endfunction

    task automatic step(input bit wv, input int wa, input int wd,
                        input bit re, input int ra, input bit sd);
        int  pending;
        bit  rdy, fv;
        int  wbk, rbk;
        @(negedge clk);
        bus.wr_valid = wv;
        bus.wr_addr  = AW'(wa);
        bus.wr_data  = MS'(wd);
        bus.rd_en    = re;
        bus.rd_addr  = AW'(ra);
        bus.sad_done = sd;
        pending = completed - released;
        rdy = pending < 2;
        fv  = pending > 0;
        wbk = completed % 2;
        rbk = released % 2;
        if (re && fv) m_rd = (ra < FRAME) ? mem[rbk][ra] : 0;
        if (wv && rdy) begin
            if (wa < FRAME) begin
                mem[wbk][wa] = wd;
                wcnt++;
                if (wcnt == FRAME) begin
                    wcnt = 0;
                    completed++;
                end
            end else begin
                m_err = 1'b1;
            end
        end
        if (sd && fv) released++;
        exp_q.push_back(model_status());
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.wr_valid = 1'b0;
        bus.rd_en    = 1'b0;
        bus.sad_done = 1'b0;
        rst_n = 1'b0;
        completed = 0;
        released  = 0;
        wcnt      = 0;
        m_err     = 1'b0;
        m_rd      = 0;
        #1;
        chk("rst_wr_ready", bus.wr_ready, 1);
        chk("rst_frame_valid", bus.frame_valid, 0);
        chk("rst_frame_cnt", bus.frame_cnt, 0);
        chk("rst_addr_err", bus.addr_err, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: one expected status per driven cycle, checked after the edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            step_no++;
            $display("txn %0d: wr_ready=%0d frame_valid=%0d frame_cnt=%0d addr_err=%0d rd_data=%0d",
                     step_no, bus.wr_ready, bus.frame_valid, bus.frame_cnt, bus.addr_err, bus.rd_data);
            chk("wr_ready", bus.wr_ready, e.rdy);
            chk("frame_valid", bus.frame_valid, e.fv);
            chk("frame_cnt", bus.frame_cnt, e.cnt);
            chk("addr_err", bus.addr_err, e.err);
            chk("rd_data", bus.rd_data, e.rd);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.rd_en    = 1'b0;
        bus.rd_addr  = '0;
        bus.sad_done = 1'b0;

        // One full frame, then read word 4 (expect 5)
        do_reset();
        for (int i = 0; i < FRAME; i++) step(1'b1, i, i + 1, 1'b0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1, 4, 1'b0);

        // Fill both banks, stalled 13th write, release, then read bank 1
        do_reset();
        for (int i = 0; i < 2 * FRAME; i++) step(1'b1, i % FRAME, $urandom_range(0, 15), 1'b0, 0, 1'b0);
        step(1'b1, 0, 9, 1'b0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 3, 1'b0);

        // Out-of-range writes flag an error but do not count
        do_reset();
        step(1'b1, 6, 3, 1'b0, 0, 1'b0);
        step(1'b1, 7, 4, 1'b0, 0, 1'b0);
        for (int i = 0; i < FRAME; i++) step(1'b1, FRAME - 1 - i, i + 8, 1'b0, 0, 1'b0);
        step(1'b0, 0, 0, 1'b1, 0, 1'b0);

        // Completion and release in the same cycle
        do_reset();
        for (int i = 0; i < FRAME; i++) step(1'b1, i, 15 - i, 1'b0, 0, 1'b0);
        for (int i = 0; i < FRAME - 1; i++) step(1'b1, i, i + 2, 1'b0, 0, 1'b0);
        step(1'b1, FRAME - 1, 12, 1'b0, 0, 1'b1);
        step(1'b0, 0, 0, 1'b1, 5, 1'b0);
        step(1'b0, 0, 0, 1'b1, 2, 1'b0);

        // Ignored release, then reset mid-frame discards the partial count
        do_reset();
        step(1'b0, 0, 0, 1'b0, 0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b1, i, i, 1'b0, 0, 1'b0);
        do_reset();
        for (int i = 0; i < FRAME; i++) step(1'b1, i, 7, 1'b0, 0, 1'b0);

        // 256 frames with interleaved release: frame_cnt wraps to 0
        do_reset();
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < FRAME; i++) step(1'b1, i, $urandom_range(0, 15), 1'b0, 0, 1'b0);
            step(1'b0, 0, 0, 1'b1, $urandom_range(0, 7), 1'b1);
        end
        @(posedge clk);
        #2;
        chk("frame_cnt_wrap", bus.frame_cnt, 0);

        // Random traffic (both banks fully written above, so reads are defined)
        for (int n = 0; n < 1500; n++) begin
            step(1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15),
                 1'($urandom_range(0, 1)), $urandom_range(0, 7), ($urandom_range(0, 5) == 0));
        end

        @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, fail_cnt);
        $finish;
    end
endmodule

// File: doc/gray_pingpong_buf.md
GRAY_PINGPONG_BUF -- requirements
Module: gray_pingpong_buf

Interface
REQ-001 SHALL have parameter CAMERA_HSIZE, default 1, pixels per line.
REQ-002 SHALL have parameter CAMERA_VSIZE, default 1, lines per frame.
REQ-003 SHALL have parameter MEAN_SIZE, default 4, grey pixel width.
REQ-004 SHALL have parameter BUF_ADDR_WIDTH, default 1, write/read address width.
REQ-005 SHALL define derived constant FRAME = CAMERA_HSIZE*CAMERA_VSIZE; each bank holds FRAME words of MEAN_SIZE bits; FRAME <= 2^BUF_ADDR_WIDTH.
REQ-006 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port wr_data  input  MEAN_SIZE  grey pixel from mean stage.
REQ-009 SHALL have port wr_addr  input  BUF_ADDR_WIDTH  linear pixel address (line*HSIZE+pixel).
REQ-010 SHALL have port wr_valid  input  1  write request, typically 1-cycle pulse.
REQ-011 SHALL have port wr_ready  output  1  write bank can accept data.
REQ-012 SHALL have port frame_valid  output  1  a complete frame is available to the SAD engine.
REQ-013 SHALL have port rd_en  input  1  SAD read strobe.
REQ-014 SHALL have port rd_addr  input  BUF_ADDR_WIDTH  SAD read address.
REQ-015 SHALL have port rd_data  output  MEAN_SIZE  registered read data.
REQ-016 SHALL have port sad_done  input  1  SAD engine finished with current frame (pulse).
REQ-017 SHALL have port frame_cnt  output  8  completed frames written, wraps 255->0.
REQ-018 SHALL have port addr_err  output  1  sticky: out-of-range write seen.

Function
REQ-019 SHALL contain two banks (0,1), per-bank full flag, write-bank pointer wb, read-bank pointer rb, and write counter wcnt (0..FRAME-1).
REQ-020 SHALL drive wr_ready = ~full[wb] combinationally; a write is accepted when wr_valid && wr_ready in the same cycle.
REQ-021 SHALL, on accepted write with wr_addr < FRAME, store wr_data at wr_addr in bank wb and increment wcnt.
REQ-022 SHALL, on accepted write with wr_addr >= FRAME, discard data, leave wcnt unchanged, set addr_err (stays 1 until reset).
REQ-023 SHALL, on the in-range accepted write with wcnt == FRAME-1, set full[wb], toggle wb, clear wcnt to 0, and increment frame_cnt, all in the same edge.
REQ-024 SHALL count writes, not unique addresses; duplicate addresses overwrite and still count.
REQ-025 SHALL drive frame_valid = full[rb] combinationally.
REQ-026 SHALL, on sad_done while frame_valid=1, clear full[rb] and toggle rb; sad_done while frame_valid=0 SHALL be ignored.
REQ-027 SHALL, when bank completion (REQ-023) and sad_done (REQ-026) occur in the same cycle, apply both (they always target different banks).
REQ-028 SHALL, when both banks are full, hold wr_ready=0 until sad_done frees a bank; the writer is stalled, not dropped.
REQ-029 SHALL, on rd_en=1 with frame_valid=1, register bank rb word rd_addr into rd_data one cycle later (latency 1).
REQ-030 SHALL hold rd_data unchanged when rd_en=0 or frame_valid=0; rd_addr >= FRAME SHALL return 0.
REQ-031 SHALL, for rd_en and sad_done in the same cycle, return data from the bank rb had before the edge.
REQ-032 SHALL allow simultaneous write to bank wb and read from bank rb every cycle.

Reset
REQ-033 SHALL, on rst_n=0, asynchronously clear full flags, wb, rb, wcnt, frame_cnt, addr_err, rd_data to 0; hence wr_ready=1, frame_valid=0.
REQ-034 SHALL not reset bank memory contents; a mid-frame reset discards the partial frame count.

Verification (HSIZE=3, VSIZE=2, MEAN_SIZE=4, BUF_ADDR_WIDTH=3)
REQ-035 SHALL verify: 6 writes addr 0..5 data 1..6 -> frame_valid=1 after 6th, frame_cnt=1, wr_ready=1; rd_addr=4 -> rd_data=5 next cycle.
REQ-036 SHALL verify: 12 writes without sad_done -> wr_ready=0 after 12th, frame_cnt=2; 13th wr_valid not accepted; sad_done -> wr_ready=1 next cycle, rd now bank 1.
REQ-037 SHALL verify: write addr 6 or 7 -> addr_err=1, wcnt unchanged, frame completes only after 6 in-range writes.
REQ-038 SHALL verify: 6th write and sad_done same cycle with bank 0 full, bank 1 filling -> full[1]=1, full[0]=0, rb=1, frame_valid stays 1.
REQ-039 SHALL verify: sad_done with frame_valid=0 -> no state change; rst_n low after 3 writes -> wcnt=0, frame_valid=0, wr_ready=1.
REQ-040 SHALL verify: frame_cnt wraps 255->0 after 256 frames with interleaved sad_done.
